sram_rw_port_arbiter: RTL and testbench
=======================================

Name: sram_rw_port_arbiter

Overview:
- Shares port 0 (RW) of the 32x256 byte-maskable 1rw1r SRAM macro between two requesters, m0 and m1.
- After reset, an optional init sequencer zero-fills all 256 words, then hands the port to a round-robin arbiter that issues at most one access per cycle.
- Sits between the SRAM macro and two bus-side masters (e.g. fabric config loader and wishbone slave).
- Port 1 (R-only) is wired straight through at top level and is outside this block.

Parameters:
- ADDR_WIDTH, 8, SRAM word address width.
- DATA_WIDTH, 32, data width; must equal 8*NUM_WMASKS.
- NUM_WMASKS, 4, byte-lane write-mask width.
- INIT_EN, 1, 1 = zero-fill the SRAM after reset; 0 = go straight to arbitration.

Ports:
- clk  in  1  clock; also drives SRAM clk0 at top level.
- rst  in  1  asynchronous active-high reset.
- mN_req  in  1  access request (N = 0,1; same set for each).
- mN_we  in  1  1 = write, 0 = read.
- mN_wmask  in  NUM_WMASKS  byte enables for a write.
- mN_addr  in  ADDR_WIDTH  word address.
- mN_wdata  in  DATA_WIDTH  write data.
- mN_gnt  out  1  request accepted at this rising edge (combinational).
- mN_rvalid  out  1  read data valid for mN this cycle (registered).
- mN_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  zero-fill complete; arbitration active.
- sram_csb0  out  1  active-low chip select to SRAM.
- sram_web0  out  1  active-low write enable.
- sram_wmask0  out  NUM_WMASKS  write mask.
- sram_addr0  out  ADDR_WIDTH  address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_dout0  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset: asynchronous and active-high; the polarity and synchronicity are fixed.
- Values while rst is high:
  - state = INIT if INIT_EN, else ARB.
  - init_cnt = 0, last_gnt = 1 (m0 wins first tie).
  - mN_rvalid = 0, init_done = INIT_EN ? 0 : 1.
  - sram_csb0 = 1 (forced while rst high), sram_web0 = 1, gnt = 0.
- SRAM drive timing: SRAM control/data outputs are combinational from state and the grant decision. The SRAM captures them at the rising edge, so the accepting edge equals the SRAM command edge.
- INIT state:
  - Each cycle drives csb0=0, web0=0, wmask0=all ones, addr0=init_cnt, din0=0.
  - init_cnt increments each cycle.
  - On the edge where init_cnt==255, moves to ARB and init_done goes to 1. Total is 256 cycles.
  - mN_gnt=0 throughout; requests are held off, not dropped by the requester.
- ARB state, per cycle:
  - Only one of m0/m1 requesting: that requester is granted.
  - Both requesting: grant the one != last_gnt.
  - Neither requesting: csb0=1, no grant, last_gnt unchanged.
  - Granted requester's we/wmask/addr/wdata are muxed onto the SRAM outputs; web0 = ~we; wmask ignored on reads.
  - last_gnt updates to the granted index at the edge.
- Grant rule: mN_gnt is asserted only in a cycle where mN_req=1. Requester holds its request and fields until it sees gnt high at a rising edge. One access per cycle; back-to-back grants allowed.
- Read response:
  - Read accepted at edge E: mN_rvalid=1 for exactly the cycle following E, i.e. E to E+1.
  - mN_rdata is a pass-through of sram_dout0, valid from the falling edge plus macro delay until E+1.
  - Consumer samples before E+1. rdata is don't-care when rvalid=0.
  - Only the granted requester's rvalid rises.
- Write:
  - No response.
  - Data lands in the SRAM at the falling edge of the accept cycle.
  - A read of the same address granted at the next edge returns the new data.
- Write/read ordering: each requester sees its accesses in request order. No ordering across requesters beyond grant order.
- Reset mid-operation:
  - Mid-INIT: the fill restarts from 0.
  - Pending rvalid is cleared and the in-flight read is lost.
  - SRAM sees csb0=1 during reset.
- Port-1 hazard is not handled here. Top level must not read-port-1 an address being written on the same edge.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - SRAM geometry constants (ADDR_WIDTH, DATA_WIDTH, NUM_WMASKS, depth 256).
  - State enum {INIT, ARB}.
  - Requester-index type.
- One natural sub-module: rr_arbiter2, a 2-way round-robin with a last-grant register and a combinational grant. It is reusable for the port-1 share later.

Test Plan:
- Reset, INIT_EN=1: count cycles until init_done=1 -> exactly 256. Then m0 reads addr 0x00, 0x7F, 0xFF -> rdata 0x00000000 each, rvalid one cycle after gnt.
- m0 write addr 0x10 data 0xDEADBEEF wmask 4'b1111, then m1 write addr 0x10 data 0x11223344 wmask 4'b0101, then m0 read 0x10 -> 0xDE22BE44.
- Both requesting continuously for 6 cycles (m0 read 0x01, m1 read 0x02) -> grants alternate m0,m1,m0,m1,m0,m1. Each rvalid goes only to its own requester with that requester's data.
- Requests asserted during INIT at cycle 10 -> gnt stays 0 until init_done. First post-init grant goes to m0 on a tie. No SRAM access is lost or duplicated.
- Assert rst at INIT cycle 100 for 2 cycles, then release -> init restarts and init_done rises 256 cycles after release. sram_csb0=1 and rvalid=0 during reset.
- Write 0xA5A5A5A5 to 0x20 then read 0x20 on the very next grant edge -> 0xA5A5A5A5.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM port-0 controller: macro geometry, FSM states
// and the requester index type.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W     = 8;
    localparam int unsigned SRAM_DATA_W     = 32;
    localparam int unsigned SRAM_NUM_WMASKS = 4;
    localparam int unsigned SRAM_DEPTH      = 256;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    typedef logic req_idx_t;

endpackage

// File: rtl/sram_rw_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
// On a tie the requester that was not granted last wins.
module rr_arbiter2
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output req_idx_t   gnt_idx,
    output logic       gnt_valid
);

    req_idx_t last_gnt;

    always_comb begin
        gnt_valid = en && (req != 2'b00);
        gnt_idx   = req_idx_t'(req[1]);
        if (req == 2'b11) begin
            gnt_idx = ~last_gnt;
        end
        gnt = 2'b00;
        if (gnt_valid) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // Reset to m1 so that m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (gnt_valid) begin
            last_gnt <= gnt_idx;
        end
    end

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// Shares the RW port of the 1rw1r SRAM macro between two requesters, with an
// optional zero-fill of every word after reset before arbitration starts.
module sram_rw_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
    parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [NUM_WMASKS-1:0] m0_wmask,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [NUM_WMASKS-1:0] m1_wmask,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  init_done,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] init_cnt_next;
    logic                  init_done_next;

    logic                  arb_en;
    logic [1:0]            req;
    logic [1:0]            gnt;
    req_idx_t              gnt_idx;
    logic                  gnt_valid;

    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // State register; reset restarts the fill from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT_EN ? ST_INIT : ST_ARB;
            init_cnt  <= '0;
            init_done <= !INIT_EN;
        end else begin
            state     <= state_next;
            init_cnt  <= init_cnt_next;
            init_done <= init_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        init_cnt_next  = init_cnt;
        init_done_next = init_done;
        case (state)
            ST_INIT: begin
                init_cnt_next = ADDR_WIDTH'(init_cnt + 1'b1);
                if (&init_cnt) begin
                    state_next     = ST_ARB;
                    init_done_next = 1'b1;
                end
            end
            ST_ARB: begin
                state_next = ST_ARB;
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    assign arb_en = !rst && (state == ST_ARB);
    assign req    = {m1_req, m0_req};

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_comb begin
        sel_we    = m0_we;
        sel_wmask = m0_wmask;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (gnt_idx) begin
            sel_we    = m1_we;
            sel_wmask = m1_wmask;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // SRAM command is combinational so the accepting edge is the macro's capture edge.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_wmask0 = '1;
                sram_addr0  = init_cnt;
            end else if (gnt_valid) begin
                sram_csb0   = 1'b0;
                sram_web0   = ~sel_we;
                sram_wmask0 = sel_wmask;
                sram_addr0  = sel_addr;
                sram_din0   = sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= gnt[0] && !m0_we;
            m1_rvalid <= gnt[1] && !m1_we;
        end
    end

    // Read data comes straight from the macro during the cycle after acceptance.
    assign m0_rdata = sram_dout0;
    assign m1_rdata = sram_dout0;

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Bench for sram_rw_port_arbiter with a behavioural 1rw SRAM port and per-requester
// read-data scoreboards.
module tb_sram_rw_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [3:0]  m0_wmask;
    logic [7:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [3:0]  m1_wmask;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        init_done;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          gnt_log[$];
    int          gnt_cyc[$];

    sram_rw_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: command captured at the rising edge, array access at the falling edge.
    logic [31:0] mem [256];
    logic        cap_csb = 1'b1;
    logic        cap_web = 1'b1;
    logic [3:0]  cap_mask;
    logic [7:0]  cap_addr;
    logic [31:0] cap_din;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        sram_dout0 = $urandom;
    end

    always @(posedge clk) begin
        cap_csb  <= sram_csb0;
        cap_web  <= sram_web0;
        cap_mask <= sram_wmask0;
        cap_addr <= sram_addr0;
        cap_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (!cap_csb) begin
            if (!cap_web) begin
                for (int b = 0; b < 4; b++)
                    if (cap_mask[b]) mem[cap_addr][b*8 +: 8] <= cap_din[b*8 +: 8];
            end else begin
                sram_dout0 <= mem[cap_addr];
            end
        end
    end

    // Grant/response monitor: grants sampled mid-cycle, accepted at the next rising edge.
    logic s_gnt0 = 1'b0, s_gnt1 = 1'b0, s_rd0 = 1'b0, s_rd1 = 1'b0;
    logic rd_pend0 = 1'b0, rd_pend1 = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (rst) begin
            s_gnt0 = 1'b0; s_gnt1 = 1'b0; s_rd0 = 1'b0; s_rd1 = 1'b0;
        end else begin
            if (rd_pend0 || m0_rvalid) begin
                checks++;
                if (m0_rvalid !== rd_pend0) begin
                    errors++;
                    $display("FAIL rvalid0 timing at cycle %0d: got %b want %b", cyc, m0_rvalid, rd_pend0);
                end
            end
            if (rd_pend1 || m1_rvalid) begin
                checks++;
                if (m1_rvalid !== rd_pend1) begin
                    errors++;
                    $display("FAIL rvalid1 timing at cycle %0d: got %b want %b", cyc, m1_rvalid, rd_pend1);
                end
            end
            if (m0_rvalid === 1'b1) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL rdata0: rvalid with no read outstanding at cycle %0d", cyc);
                end else begin
                    e = exp0.pop_front();
                    if (m0_rdata !== e) begin
                        errors++;
                        $display("FAIL rdata0 at cycle %0d: got %h want %h", cyc, m0_rdata, e);
                    end
                end
            end
            if (m1_rvalid === 1'b1) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL rdata1: rvalid with no read outstanding at cycle %0d", cyc);
                end else begin
                    e = exp1.pop_front();
                    if (m1_rdata !== e) begin
                        errors++;
                        $display("FAIL rdata1 at cycle %0d: got %h want %h", cyc, m1_rdata, e);
                    end
                end
            end
            if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                checks++;
                if ((m0_gnt && !m0_req) || (m1_gnt && !m1_req) || (m0_gnt && m1_gnt) || !init_done) begin
                    errors++;
                    $display("FAIL grant legality at cycle %0d: gnt=%b%b req=%b%b init_done=%b",
                             cyc, m1_gnt, m0_gnt, m1_req, m0_req, init_done);
                end
            end
            s_gnt0 = m0_gnt; s_gnt1 = m1_gnt;
            s_rd0  = m0_gnt && !m0_we;
            s_rd1  = m1_gnt && !m1_we;
        end
    end

    always @(posedge clk) begin
        rd_pend0 <= s_rd0;
        rd_pend1 <= s_rd1;
        if (s_gnt0) begin gnt_log.push_back(0); gnt_cyc.push_back(cyc); end
        if (s_gnt1) begin gnt_log.push_back(1); gnt_cyc.push_back(cyc); end
    end

    // One requester transaction; for reads 'data' is the expected read data.
    task automatic access(input int idx, input logic we, input logic [3:0] mask,
                          input logic [7:0] addr, input logic [31:0] data);
        int n = 0;
        bit g;
        if (idx == 0) begin
            m0_req = 1'b1; m0_we = we; m0_wmask = mask; m0_addr = addr; m0_wdata = we ? data : 32'h0;
            if (!we) exp0.push_back(data);
        end else begin
            m1_req = 1'b1; m1_we = we; m1_wmask = mask; m1_addr = addr; m1_wdata = we ? data : 32'h0;
            if (!we) exp1.push_back(data);
        end
        forever begin
            @(negedge clk);
            #1;
            g = (idx == 0) ? m0_gnt : m1_gnt;
            @(posedge clk);
            if (g) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL grant timeout m%0d addr %h: got no grant want grant", idx, addr);
                break;
            end
        end
        #1;
        if (idx == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic count_init(input string name);
        int n = 0;
        forever begin
            @(posedge clk);
            n++;
            #1;
            if (init_done === 1'b1 || n > 1000) break;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL %s init length: got %0d cycles want 256", name, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #3;
        checks++;
        if (sram_csb0 !== 1'b1 || init_done !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 ||
            m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got csb=%b done=%b rv=%b%b gnt=%b%b want csb=1 done=0 rv=00 gnt=00",
                     sram_csb0, init_done, m1_rvalid, m0_rvalid, m1_gnt, m0_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        count_init("power-on");
    endtask

    task automatic test_zero_reads();
        access(0, 1'b0, 4'h0, 8'h00, 32'h0);
        access(0, 1'b0, 4'h0, 8'h7F, 32'h0);
        access(0, 1'b0, 4'h0, 8'hFF, 32'h0);
    endtask

    task automatic test_byte_mask();
        access(0, 1'b1, 4'b1111, 8'h10, 32'hDEADBEEF);
        access(1, 1'b1, 4'b0101, 8'h10, 32'h11223344);
        access(0, 1'b0, 4'h0,    8'h10, 32'hDE22BE44);
    endtask

    task automatic test_alternate();
        access(0, 1'b1, 4'hF, 8'h01, 32'h0101_0A0A);
        access(1, 1'b1, 4'hF, 8'h02, 32'h0202_0B0B);
        gnt_log.delete();
        gnt_cyc.delete();
        fork
            repeat (3) access(0, 1'b0, 4'h0, 8'h01, 32'h0101_0A0A);
            repeat (3) access(1, 1'b0, 4'h0, 8'h02, 32'h0202_0B0B);
        join
        checks++;
        if (gnt_log.size() != 6) begin
            errors++;
            $display("FAIL alternate grant count: got %0d want 6", gnt_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (gnt_log[i] != (i % 2) || (i > 0 && gnt_cyc[i] != gnt_cyc[i-1] + 1)) begin
                    errors++;
                    $display("FAIL alternate grant %0d: got m%0d at cycle %0d want m%0d back-to-back",
                             i, gnt_log[i], gnt_cyc[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        gnt_log.delete();
        gnt_cyc.delete();
        access(0, 1'b1, 4'hF, 8'h20, 32'hA5A5A5A5);
        access(0, 1'b0, 4'h0, 8'h20, 32'hA5A5A5A5);
        checks++;
        if (gnt_cyc.size() != 2 || gnt_cyc[1] != gnt_cyc[0] + 1) begin
            errors++;
            $display("FAIL back_to_back spacing: got %0d grants want 2 on consecutive edges", gnt_cyc.size());
        end
    endtask

    task automatic test_req_during_init();
        pulse_reset(1);
        repeat (10) @(posedge clk);
        #1;
        gnt_log.delete();
        gnt_cyc.delete();
        fork
            access(0, 1'b0, 4'h0, 8'h05, 32'h0);
            access(1, 1'b0, 4'h0, 8'h06, 32'h0);
        join
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 1) begin
            errors++;
            $display("FAIL init_hold grant order: got %0d grants first m%0d want 2 grants m0 then m1",
                     gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : -1);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL init_hold reads outstanding: got %0d/%0d want 0/0", exp0.size(), exp1.size());
        end
    endtask

    task automatic test_reset_mid_init();
        pulse_reset(1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk); #3;
        checks++;
        if (sram_csb0 !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_init reset outputs: got csb=%b rv=%b%b done=%b want 1 00 0",
                     sram_csb0, m1_rvalid, m0_rvalid, init_done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk); #3;
        checks++;
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 8'h00 || sram_wmask0 !== 4'hF ||
            sram_din0 !== 32'h0) begin
            errors++;
            $display("FAIL mid_init restart: got csb=%b web=%b addr=%h mask=%h din=%h want 0 0 00 f 0",
                     sram_csb0, sram_web0, sram_addr0, sram_wmask0, sram_din0);
        end
        count_init("restart");
        access(1, 1'b0, 4'h0, 8'h20, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_wmask = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_wmask = '0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_zero_reads();
        test_byte_mask();
        test_alternate();
        test_back_to_back();
        test_req_during_init();
        test_reset_mid_init();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL final scoreboard: got %0d/%0d outstanding reads want 0/0", exp0.size(), exp1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
